seq_mult4: RTL and testbench

Sequential 4x4 unsigned shift-and-add multiplier producing an 8-bit product. It sits directly downstream of `fourBitAdder`: it instantiates one adder, consumes its `sum` and `cout` on every iteration, and registers the partial product between cycles. It is the first clocked arithmetic block in the adder library and the template for later multi-cycle datapath units.

---
 rtl/seq_mult4_pkg.sv | 10 +
 rtl/seq_mult4_adder.sv | 26 ++
 rtl/seq_mult4.sv | 79 +++++++
 tb/tb_seq_mult4.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seq_mult4_pkg.sv
// seq_mult4_pkg: shared state encoding, iteration count and counter width for seq_mult4.
package seq_mult4_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int ITER  = 4;
    localparam int CNT_W = 2;
endpackage

// File: rtl/seq_mult4_adder.sv
// seq_mult4_adder: ripple-carry fourBitAdder built from fullAdder cells.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module fourBitAdder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    assign cout = c[4];
    for (genvar i = 0; i < 4; i++) begin : g_fa
        fullAdder u_fa (.a(A[i]), .b(B[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
    end
endmodule

// File: rtl/seq_mult4.sv
// seq_mult4: sequential 4x4 unsigned shift-and-add multiplier, one iteration per cycle.
module seq_mult4
    import seq_mult4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       ready,
    output logic       done,
    output logic [7:0] product
);
    state_t           state_q, state_d;
    logic [3:0]       m_q, m_d, q_q, q_d, a_q, a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [7:0]       product_q, product_d;
    logic [3:0]       s;
    logic             c;
    fourBitAdder u_add (
        .A(a_q),
        .B(q_q[0] ? m_q : 4'b0),
        .cin(1'b0),
        .sum(s),
        .cout(c)
    );
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                m_d     = a;
                q_d     = b;
                a_d     = 4'b0;
                cnt_d   = '0;
            end
            RUN: begin
                a_d   = {c, s[3:1]};
                q_d   = {s[0], q_q[3:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    product_d = {a_d, q_d};
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            a_q       <= a_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end
    assign ready   = state_q == IDLE;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_seq_mult4.sv
// tb_seq_mult4: table-driven, random and corner-case checks of seq_mult4 against plain multiplication.
module tb_seq_mult4;
    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic [3:0] a = 0, b = 0;
    logic       ready, done;
    logic [7:0] product;
    int errors = 0, checks = 0, cyc = 0, done_cnt = 0;

    seq_mult4 dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                   .ready(ready), .done(done), .product(product));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge done) done_cnt <= done_cnt + 1;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issues one request at the next ready cycle; returns product at done, latency in edges and accept cycle.
    task automatic mult(input logic [3:0] ta, input logic [3:0] tb, input logic toggle,
                        output logic [7:0] p, output int lat, output int acc);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        a = ta;
        b = tb;
        start = 1;
        @(negedge clk);
        if (!toggle) start = 0;
        lat = 0;
        while (!done && lat < 12) begin
            if (toggle) begin
                a = 4'($urandom);
                b = 4'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        p = product;
    endtask

    vec_t tbl[8];
    logic [7:0] p;
    int lat, acc0, acc1, dc;

    initial begin
        tbl[0] = '{4'd5, 4'd9, 8'h2D};
        tbl[1] = '{4'd15, 4'd15, 8'hE1};
        tbl[2] = '{4'd0, 4'd11, 8'h00};
        tbl[3] = '{4'd1, 4'd10, 8'h0A};
        tbl[4] = '{4'd3, 4'd5, 8'h0F};
        tbl[5] = '{4'd0, 4'd0, 8'h00};
        tbl[6] = '{4'd15, 4'd1, 8'h0F};
        tbl[7] = '{4'd1, 4'd15, 8'h0F};

        #1;
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_product", product, 0);
        @(negedge clk);
        rst = 0;

        foreach (tbl[i]) begin
            mult(tbl[i].a, tbl[i].b, 0, p, lat, acc0);
            check($sformatf("tbl%0d_product", i), p, tbl[i].exp);
            check($sformatf("tbl%0d_latency", i), lat, 4);
            @(negedge clk);
            check($sformatf("tbl%0d_ready_after", i), ready, 1);
            check($sformatf("tbl%0d_done_pulse", i), done, 0);
        end

        for (int i = 0; i < 20; i++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom);
            rb = 4'($urandom);
            mult(ra, rb, 0, p, lat, acc0);
            check($sformatf("rand%0d_%0dx%0d", i, ra, rb), p, 8'(ra * rb));
        end

        mult(4'd6, 4'd11, 1, p, lat, acc0);
        check("hold_first_product", p, 8'd66);
        mult(4'd13, 4'd7, 1, p, lat, acc1);
        check("hold_second_product", p, 8'd91);
        check("hold_accept_spacing", acc1 - acc0, 6);
        start = 0;

        mult(4'd3, 4'd5, 0, p, lat, acc0);
        check("pre_abort_product", p, 8'h0F);
        dc = done_cnt;
        @(negedge clk);
        a = 7;
        b = 7;
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        rst = 1;
        #1;
        check("abort_product_async", product, 0);
        check("abort_ready_async", ready, 1);
        @(negedge clk);
        rst = 0;
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt, dc);
        check("abort_ready", ready, 1);
        check("abort_product", product, 0);
        mult(4'd2, 4'd3, 0, p, lat, acc0);
        check("post_abort_product", p, 8'h06);

        mult(4'd9, 4'd9, 0, p, lat, acc0);
        check("async_pre_done", done, 1);
        #1;
        rst = 1;
        #1;
        check("async_done", done, 0);
        check("async_product", product, 0);
        check("async_ready", ready, 1);
        @(negedge clk);
        rst = 0;
        mult(4'd12, 4'd10, 0, p, lat, acc0);
        check("final_product", p, 8'd120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end
endmodule
